// File: rtl/net_bus_pkg.sv
// NetBus shared definitions: flit field positions, the flit width and command codes.
package net_bus_pkg;

  // Flit field positions, with bit 0 as the LSB.
  localparam int LAST_BIT  = 0;
  localparam int FIRST_BIT = 1;
  localparam int SID_LSB   = 2;
  localparam int DID_LSB   = 7;
  localparam int CMD_LSB   = 12;
  localparam int STRB_LSB  = 14;

  localparam int SID_W = 5;
  localparam int DID_W = 5;
  localparam int CMD_W = 2;

  typedef enum logic [1:0] {
    CMD_READ  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_MSG   = 2'b10,
    CMD_RESP  = 2'b11
  } cmd_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BEAT = 1'b1
  } state_e;

  // Flit width: one data byte plus one strobe bit per lane, plus 14 header bits.
  function automatic int flit_width(input int data_width);
    return data_width * 9 + 14;
  endfunction

endpackage

// File: rtl/net_bus_out_slot.sv
// One-entry registered valid/ready slot. The slot can drain and refill in the
// same cycle because in_ready passes out_ready straight through.
module net_bus_out_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_r;
  logic [W-1:0] data_r;

  assign in_ready  = !valid_r || out_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Slot register: load on an input handshake, clear when drained with no refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (in_valid && in_ready) begin
      valid_r <= 1'b1;
      data_r  <= in_data;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: rtl/net_bus_packer.sv
// NetBus transmit framer: latches a descriptor, then packs each payload beat
// into one flit with FIRST/LAST framing, delivered through a registered slot.
module net_bus_packer
  import net_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int LEN_W      = 8
) (
  input  logic                              CLK,
  input  logic                              RESETN,
  input  logic                              HDR_VALID,
  output logic                              HDR_READY,
  input  logic [1:0]                        HDR_CMD,
  input  logic [4:0]                        HDR_DID,
  input  logic [4:0]                        HDR_SID,
  input  logic [LEN_W-1:0]                  HDR_LEN,
  input  logic                              IN_VALID,
  output logic                              IN_READY,
  input  logic [DATA_WIDTH*8-1:0]           IN_DATA,
  input  logic [DATA_WIDTH-1:0]             IN_STRB,
  output logic                              OUT_VALID,
  input  logic                              OUT_READY,
  output logic [flit_width(DATA_WIDTH)-1:0] OUT_DATA,
  output logic                              BUSY,
  output logic                              PKT_DONE
);

  localparam int FW = flit_width(DATA_WIDTH);

  state_e             state_r;
  state_e             state_next_s;
  logic [CMD_W-1:0]   cmd_r;
  logic [DID_W-1:0]   did_r;
  logic [SID_W-1:0]   sid_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   cnt_r;
  logic               hdr_ready_s;
  logic               beat_en_s;
  logic               slot_in_valid_s;
  logic               slot_in_ready_s;
  logic               hdr_hs_s;
  logic               beat_hs_s;
  logic               first_s;
  logic               last_s;
  logic [FW-1:0]      flit_s;
  logic               pkt_done_r;

  assign first_s         = (cnt_r == {LEN_W{1'b0}});
  assign last_s          = (cnt_r == len_r);
  assign hdr_hs_s        = HDR_VALID && hdr_ready_s;
  assign slot_in_valid_s = IN_VALID && beat_en_s;
  assign beat_hs_s       = slot_in_valid_s && slot_in_ready_s;

  assign HDR_READY = hdr_ready_s;
  assign IN_READY  = beat_en_s && slot_in_ready_s;
  assign BUSY      = (state_r == ST_BEAT) || OUT_VALID;
  assign PKT_DONE  = pkt_done_r;

  // State register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and handshake enables.
  always_comb begin
    state_next_s = state_r;
    hdr_ready_s  = 1'b0;
    beat_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        hdr_ready_s = 1'b1;
        if (HDR_VALID) begin
          state_next_s = ST_BEAT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BEAT: begin
        beat_en_s = 1'b1;
        if (beat_hs_s && last_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_BEAT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Descriptor latch and beat counter; the counter clears on LAST so it never wraps.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cmd_r <= {CMD_W{1'b0}};
      did_r <= {DID_W{1'b0}};
      sid_r <= {SID_W{1'b0}};
      len_r <= {LEN_W{1'b0}};
      cnt_r <= {LEN_W{1'b0}};
    end else if (hdr_hs_s) begin
      cmd_r <= HDR_CMD;
      did_r <= HDR_DID;
      sid_r <= HDR_SID;
      len_r <= HDR_LEN;
      cnt_r <= {LEN_W{1'b0}};
    end else if (beat_hs_s) begin
      if (last_s) begin
        cnt_r <= {LEN_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Field packing of the current beat into a flit.
  always_comb begin
    flit_s                                    = {FW{1'b0}};
    flit_s[LAST_BIT]                          = last_s;
    flit_s[FIRST_BIT]                         = first_s;
    flit_s[SID_LSB +: SID_W]                  = sid_r;
    flit_s[DID_LSB +: DID_W]                  = did_r;
    flit_s[CMD_LSB +: CMD_W]                  = cmd_r;
    flit_s[STRB_LSB +: DATA_WIDTH]            = IN_STRB;
    flit_s[STRB_LSB + DATA_WIDTH +: DATA_WIDTH*8] = IN_DATA;
  end

  net_bus_out_slot #(.W(FW)) u_slot (
    .clk       (CLK),
    .rst_n     (RESETN),
    .in_valid  (slot_in_valid_s),
    .in_ready  (slot_in_ready_s),
    .in_data   (flit_s),
    .out_valid (OUT_VALID),
    .out_ready (OUT_READY),
    .out_data  (OUT_DATA)
  );

  // Packet-done pulse, one cycle after the LAST flit leaves the slot.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pkt_done_r <= 1'b0;
    end else begin
      pkt_done_r <= OUT_VALID && OUT_READY && OUT_DATA[LAST_BIT];
    end
  end

endmodule

// File: tb/tb_net_bus_packer.sv
// Randomized self-checking bench for net_bus_packer against a packet-level model.
module tb_net_bus_packer;

  localparam int DW = 4;
  localparam int LW = 4;
  localparam int FW = DW * 9 + 14;

  logic          CLK = 1'b0;
  logic          RESETN;
  logic          HDR_VALID;
  logic          HDR_READY;
  logic [1:0]    HDR_CMD;
  logic [4:0]    HDR_DID;
  logic [4:0]    HDR_SID;
  logic [LW-1:0] HDR_LEN;
  logic          IN_VALID;
  logic          IN_READY;
  logic [DW*8-1:0] IN_DATA;
  logic [DW-1:0] IN_STRB;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [FW-1:0] OUT_DATA;
  logic          BUSY;
  logic          PKT_DONE;

  net_bus_packer #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .HDR_VALID(HDR_VALID), .HDR_READY(HDR_READY),
    .HDR_CMD(HDR_CMD), .HDR_DID(HDR_DID), .HDR_SID(HDR_SID), .HDR_LEN(HDR_LEN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_STRB(IN_STRB),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .BUSY(BUSY), .PKT_DONE(PKT_DONE)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Packet-level reference model state.
  logic [FW-1:0] exp_q[$];
  bit            m_active = 1'b0;
  logic [1:0]    m_cmd;
  logic [4:0]    m_did;
  logic [4:0]    m_sid;
  int            m_len;
  int            m_idx;
  bit            exp_done = 1'b0;
  bit            hold_chk = 1'b0;
  logic [FW-1:0] hold_data;
  bit            hdr_hs;
  bit            in_hs;
  int            n_out;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A flit as the NetBus format defines it, MSB first.
  function automatic logic [FW-1:0] mk_flit(input logic [1:0] cmd, input logic [4:0] did,
      input logic [4:0] sid, input bit first, input bit last,
      input logic [DW-1:0] strb, input logic [DW*8-1:0] data);
    return {data, strb, cmd, did, sid, first, last};
  endfunction

  // One clock: compare outputs against the model, update the model, advance to next negedge.
  task automatic cycle();
    logic [FW-1:0] f;
    bit out_hs;
    #1;
    check_eq("pkt_done", PKT_DONE, exp_done);
    check_eq("out_valid", OUT_VALID, exp_q.size() != 0);
    check_eq("busy", BUSY, m_active || exp_q.size() != 0);
    check_eq("hdr_ready", HDR_READY, !m_active);
    check_eq("in_ready", IN_READY, m_active && (exp_q.size() == 0 || OUT_READY));
    if (hold_chk) check_eq("hold_data", OUT_DATA, hold_data);
    out_hs = OUT_VALID && OUT_READY;
    hdr_hs = HDR_VALID && HDR_READY;
    in_hs  = IN_VALID && IN_READY;
    exp_done = 1'b0;
    if (out_hs) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_flit", 64'd1, 64'd0);
      end else begin
        f = exp_q.pop_front();
        check_eq("flit", OUT_DATA, f);
        exp_done = f[0];
        n_out++;
      end
    end
    hold_chk  = OUT_VALID && !OUT_READY;
    hold_data = OUT_DATA;
    if (hdr_hs) begin
      m_cmd = HDR_CMD; m_did = HDR_DID; m_sid = HDR_SID;
      m_len = int'(HDR_LEN); m_idx = 0; m_active = 1'b1;
    end
    if (in_hs) begin
      if (!m_active) begin
        check_eq("idle_beat_taken", 64'd1, 64'd0);
      end else begin
        exp_q.push_back(mk_flit(m_cmd, m_did, m_sid, m_idx == 0, m_idx == m_len, IN_STRB, IN_DATA));
        if (m_idx == m_len) m_active = 1'b0;
        m_idx++;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESETN = 1'b0;
    HDR_VALID = 1'b0; IN_VALID = 1'b0;
    #1;
    check_eq("rst_out_valid", OUT_VALID, 64'd0);
    check_eq("rst_out_data", OUT_DATA, 64'd0);
    check_eq("rst_pkt_done", PKT_DONE, 64'd0);
    check_eq("rst_busy", BUSY, 64'd0);
    exp_q.delete();
    m_active = 1'b0; exp_done = 1'b0; hold_chk = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RESETN = 1'b1;
    #1;
    check_eq("rel_hdr_ready", HDR_READY, 64'd1);
    check_eq("rel_in_ready", IN_READY, 64'd0);
    @(negedge CLK);
  endtask

  // mode: 0 ready always, 1 random ready, 2 five-cycle stall mid-packet.
  task automatic run_packet(input logic [1:0] cmd, input logic [4:0] did, input logic [4:0] sid,
      input int len, input int mode, input bit gaps, input int rst_after,
      input logic [31:0] d0, input logic [3:0] s0);
    int beat = 0;
    int guard = 0;
    int stalls = 0;
    logic [31:0] d = d0;
    logic [3:0]  s = s0;
    n_out = 0;
    HDR_VALID = 1'b1; HDR_CMD = cmd; HDR_DID = did; HDR_SID = sid; HDR_LEN = LW'(len);
    IN_VALID = 1'b0;
    while ((HDR_VALID || beat <= len || exp_q.size() != 0) && guard < 2000) begin
      if (rst_after != 0 && beat == rst_after) begin
        check_eq("pre_rst_valid", OUT_VALID, 64'd1);
        do_reset();
        return;
      end
      case (mode)
        0: OUT_READY = 1'b1;
        1: OUT_READY = ($urandom_range(0, 2) != 0);
        default: OUT_READY = !(guard >= 3 && guard <= 7);
      endcase
      if (!HDR_VALID && beat <= len) begin
        IN_VALID = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        IN_DATA = d; IN_STRB = s;
      end else begin
        IN_VALID = 1'b0;
      end
      cycle();
      if (IN_VALID && !in_hs) stalls++;
      if (hdr_hs) HDR_VALID = 1'b0;
      if (in_hs) begin
        beat++;
        d = $urandom; s = 4'($urandom);
      end
      guard++;
    end
    if (guard >= 2000) check_eq("timeout", 64'd1, 64'd0);
    if (mode == 0 && !gaps) check_eq("stream_stalls", stalls, 64'd0);
    check_eq("flit_count", n_out, len + 1);
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    cycle();
  endtask

  initial begin
    RESETN = 1'b0; HDR_VALID = 1'b0; HDR_CMD = 2'b00; HDR_DID = 5'd0; HDR_SID = 5'd0;
    HDR_LEN = '0; IN_VALID = 1'b0; IN_DATA = '0; IN_STRB = '0; OUT_READY = 1'b1;
    @(negedge CLK);
    do_reset();

    // Single-beat packet.
    run_packet(2'b01, 5'd3, 5'd7, 0, 0, 1'b0, 0, 32'hDEADBEEF, 4'hF);
    // Four-beat streaming.
    run_packet(2'b10, 5'd12, 5'd1, 3, 0, 1'b0, 0, $urandom, 4'($urandom));
    // Backpressure mid-packet.
    run_packet(2'b11, 5'd30, 5'd9, 5, 2, 1'b0, 0, $urandom, 4'h0);
    // Maximum length with random downstream readiness.
    run_packet(2'b00, 5'd31, 5'd31, 15, 1, 1'b1, 0, $urandom, 4'($urandom));

    // Payload offered while idle must be ignored.
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IN_VALID = 1'b1; IN_DATA = $urandom; IN_STRB = 4'($urandom);
      cycle();
    end
    IN_VALID = 1'b0;
    run_packet(2'b01, 5'd5, 5'd6, 2, 0, 1'b0, 0, $urandom, 4'($urandom));

    // Reset after beat 2 of 4, then a clean packet.
    run_packet(2'b10, 5'd8, 5'd4, 3, 0, 1'b0, 2, $urandom, 4'($urandom));
    run_packet(2'b01, 5'd2, 5'd3, 1, 0, 1'b0, 0, $urandom, 4'($urandom));

    // Random packets.
    for (int p = 0; p < 8; p++) begin
      run_packet(2'($urandom), 5'($urandom), 5'($urandom), $urandom_range(0, 15),
                 $urandom_range(0, 2), 1'($urandom), 0, $urandom, 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/net_bus_packer.md
Name: net_bus_packer

Overview:
- Transmit-side framer for the NetBus flit format.
- Accepts a packet descriptor (CMD, DID, SID, beat count) plus a stream of payload beats (data + byte strobes).
- Emits one fully packed flit per beat, with FIRST and LAST framing bits, on a registered valid/ready output.
- Sits between a master/DMA engine and the NetBus router input port; the router-side field splitter is its counterpart.

Parameters:
- DATA_WIDTH, 4: payload bytes per beat; flit width FW = DATA_WIDTH*9+14.
- LEN_W, 8: width of the descriptor beat-count field; packet length = HDR_LEN+1 beats (1..2^LEN_W).

Ports:
- CLK  in  1  clock, all logic rising-edge.
- RESETN  in  1  asynchronous active-low reset.
- HDR_VALID  in  1  descriptor valid.
- HDR_READY  out  1  descriptor accepted when both HDR_VALID and HDR_READY are high.
- HDR_CMD  in  2  command code.
- HDR_DID  in  5  destination ID.
- HDR_SID  in  5  source ID.
- HDR_LEN  in  LEN_W  beats minus one.
- IN_VALID  in  1  payload beat valid.
- IN_READY  out  1  payload beat accepted when both IN_VALID and IN_READY are high.
- IN_DATA  in  DATA_WIDTH*8  payload bytes.
- IN_STRB  in  DATA_WIDTH  byte enables.
- OUT_VALID  out  1  flit valid.
- OUT_READY  in  1  downstream ready.
- OUT_DATA  out  FW  packed flit.
- BUSY  out  1  packet in progress (state BEAT or output slot full).
- PKT_DONE  out  1  one-cycle pulse when the LAST flit is accepted downstream.

Behaviour:
- Clock and reset: one clock CLK; reset RESETN, asynchronous assert, active-low. Asserting it clears all state and registers immediately.
- Reset values: state=IDLE, OUT_VALID=0, OUT_DATA=0, PKT_DONE=0, beat counter=0, header regs=0. HDR_READY=1 and IN_READY=0 after reset release.
- Flit layout (bit 0 = LSB):
  - [0] LAST
  - [1] FIRST
  - [6:2] SID
  - [11:7] DID
  - [13:12] CMD
  - [DATA_WIDTH+13:14] STRB
  - [FW-1:DATA_WIDTH+14] DATA
- FSM IDLE:
  - HDR_READY=1, IN_READY=0.
  - On a descriptor handshake: latch CMD/DID/SID/LEN, clear the counter, go to BEAT.
- FSM BEAT:
  - HDR_READY=0.
  - IN_READY = !OUT_VALID || OUT_READY, so the single output slot can drain and refill in the same cycle.
  - On a beat handshake, load the output slot on the next edge:
    - FIRST = (cnt==0)
    - LAST = (cnt==LEN)
    - header fields from the latched regs
    - STRB and DATA from the input
  - Then cnt++. On the LAST beat, go to IDLE.
- Latency: a beat accepted at edge k appears on OUT_DATA with OUT_VALID=1 after edge k. A new descriptor can be accepted in the cycle after the LAST beat handshake. Sustained throughput is 1 flit/clk when OUT_READY is held high.
- Output stability: while OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_VALID hold unchanged.
- Slot drain: OUT_VALID clears on an output handshake with no new beat accepted in that cycle.
- Single-beat packet (HDR_LEN=0): the flit carries FIRST=1 and LAST=1.
- Maximum length (HDR_LEN=2^LEN_W-1): the counter is LEN_W bits and must never wrap before LAST.
- Payload while IDLE: IN_VALID asserted in IDLE is ignored (IN_READY=0) and no flit is generated.
- STRB: passed through unmodified; all-zero strobes are legal.
- PKT_DONE: registered; high the cycle after the LAST flit's output handshake.
- Reset mid-packet: the in-flight flit is dropped, OUT_VALID drops immediately, the state returns to IDLE, and no partial LAST is emitted.

Decomposition:
- Shared package net_bus_pkg holds:
  - bit-position constants LAST_BIT, FIRST_BIT, SID_LSB, DID_LSB, CMD_LSB, STRB_LSB;
  - the FW width function;
  - CMD encodings.
- One sub-module, net_bus_out_slot: a 1-entry registered valid/ready slot with pass-through ready. It is reusable by the other NetBus masters.
- The FSM, counter and field packing stay in net_bus_packer.

Test Plan:
- Single-beat packet: descriptor CMD=2'b01, DID=5'd3, SID=5'd7, LEN=0; beat DATA=32'hDEADBEEF, STRB=4'hF; OUT_READY=1. Expect exactly one flit with FIRST=1, LAST=1, fields at the documented bits, PKT_DONE pulsing one cycle later.
- Four-beat streaming: LEN=3, four back-to-back beats, OUT_READY=1. Expect 4 flits on consecutive cycles: FIRST only on beat 0, LAST only on beat 3, and HDR_READY=1 in the cycle after the last input handshake.
- Backpressure: OUT_READY=0 for 5 cycles mid-packet. Expect OUT_DATA stable and IN_READY=0 while the slot is full; no beat is lost or duplicated; order is preserved.
- Maximum length with LEN_W=4: LEN=15, OUT_READY random. Expect 16 flits, LAST on the 16th, and no counter wrap.
- Illegal payload: IN_VALID=1 while IDLE. Expect IN_READY=0 and no output; a later descriptor then produces correctly framed flits.
- Reset mid-packet: RESETN low after beat 2 of 4. Expect OUT_VALID=0 immediately and HDR_READY=1 after release; the next packet starts with FIRST=1.
